// File: rtl/lfsr_stream_cipher.sv
// lfsr_stream_cipher: byte-stream XOR cipher keyed by a Fibonacci LFSR.
// Define LFSR_CIPHER_PERR_EN to build the decrypt parity checker.
module lfsr_stream_cipher #(
    parameter int unsigned       LFSR_W   = 7,
    parameter int unsigned       DATA_W   = 8,
    parameter logic [DATA_W-1:0] PAD_CHAR = 8'h20
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cfg_load,
    input  logic [LFSR_W-1:0] cfg_taps,
    input  logic [LFSR_W-1:0] cfg_seed,
    input  logic [1:0]        cfg_mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_perr,
    output logic              seed_err,
    output logic [LFSR_W-1:0] seed_out,
    output logic [7:0]        perr_cnt
);

    localparam int PW = DATA_W - 1;

    typedef enum logic [1:0] {
        UNCFG = 2'd0,
        SEED  = 2'd1,
        RUN   = 2'd2
    } fsm_e;

    fsm_e              fsm_q, fsm_d;
    logic [LFSR_W-1:0] taps_q, taps_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [LFSR_W-1:0] seed_q, seed_d;
    logic [1:0]        mode_q, mode_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_perr_q, out_perr_d;
    logic              seed_err_q, seed_err_d;
    logic [7:0]        perr_cnt_q, perr_cnt_d;

    logic              in_fire;
    logic              chk_err;
    logic [PW-1:0]     ks;
    logic [PW-1:0]     xored;
    logic [LFSR_W-1:0] rec_seed;
    logic [LFSR_W-1:0] cfg_seed_nz;

    function automatic logic [LFSR_W-1:0] lfsr_step(
        input logic [LFSR_W-1:0] s,
        input logic [LFSR_W-1:0] t
    );
        return {s[LFSR_W-2:0], ^(s & t)};
    endfunction

    assign in_ready = (fsm_q != UNCFG) && !cfg_load &&
                      (!out_valid_q || out_ready);
    assign in_fire  = in_valid && in_ready;

    assign ks          = PW'(lfsr_q);
    assign xored       = in_data[PW-1:0] ^ ks;
    assign rec_seed    = in_data[LFSR_W-1:0] ^ PAD_CHAR[LFSR_W-1:0];
    assign cfg_seed_nz = (cfg_seed == '0) ? LFSR_W'(1) : cfg_seed;

`ifdef LFSR_CIPHER_PERR_EN
    assign chk_err = in_data[DATA_W-1] ^ (^in_data[PW-1:0]);
`else
    logic msb_unused;
    assign msb_unused = in_data[DATA_W-1];
    assign chk_err    = 1'b0;
`endif

    always_comb begin
        fsm_d       = fsm_q;
        taps_d      = taps_q;
        lfsr_d      = lfsr_q;
        seed_d      = seed_q;
        mode_d      = mode_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_perr_d  = out_perr_q;
        seed_err_d  = seed_err_q;
        perr_cnt_d  = perr_cnt_q;

        if (cfg_load) begin
            // Restart: pending output is dropped, any input this cycle is refused.
            taps_d      = cfg_taps;
            seed_d      = cfg_seed_nz;
            lfsr_d      = cfg_seed_nz;
            mode_d      = (cfg_mode == 2'd3) ? 2'd1 : cfg_mode;
            fsm_d       = (cfg_mode == 2'd2) ? SEED : RUN;
            out_valid_d = 1'b0;
            out_perr_d  = 1'b0;
            seed_err_d  = 1'b0;
            perr_cnt_d  = 8'd0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
`ifdef LFSR_CIPHER_PERR_EN
                if (out_perr_q && perr_cnt_q != 8'hFF)
                    perr_cnt_d = perr_cnt_q + 8'd1;
`endif
            end
            if (in_fire) begin
                out_valid_d = 1'b1;
                unique case (1'b1)
                    fsm_q == SEED: begin
                        out_data_d = PAD_CHAR;
                        out_perr_d = chk_err;
                        if (rec_seed == '0) begin
                            seed_err_d = 1'b1;
                        end else begin
                            seed_d = rec_seed;
                            lfsr_d = lfsr_step(rec_seed, taps_q);
                            fsm_d  = RUN;
                        end
                    end
                    mode_q == 2'd0: begin
                        out_data_d = {^xored, xored};
                        out_perr_d = 1'b0;
                        lfsr_d     = lfsr_step(lfsr_q, taps_q);
                    end
                    default: begin
                        out_data_d = {1'b0, xored};
                        out_perr_d = chk_err;
                        lfsr_d     = lfsr_step(lfsr_q, taps_q);
                    end
                endcase
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            fsm_q       <= UNCFG;
            taps_q      <= '0;
            lfsr_q      <= '0;
            seed_q      <= '0;
            mode_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_perr_q  <= 1'b0;
            seed_err_q  <= 1'b0;
            perr_cnt_q  <= '0;
        end else begin
            fsm_q       <= fsm_d;
            taps_q      <= taps_d;
            lfsr_q      <= lfsr_d;
            seed_q      <= seed_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_perr_q  <= out_perr_d;
            seed_err_q  <= seed_err_d;
            perr_cnt_q  <= perr_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_perr  = out_perr_q;
    assign seed_err  = seed_err_q;
    assign seed_out  = seed_q;
    assign perr_cnt  = perr_cnt_q;

endmodule

// File: doc/lfsr_stream_cipher.md
# lfsr_stream_cipher

Parametrised streaming LFSR cipher engine: the hardware successor to the software encrypt/decrypt programs. It takes bytes on a valid/ready stream and XORs them with a configurable-width Fibonacci LFSR keystream. The block supports three modes: encrypt with parity prepend, decrypt with parity check, and decrypt with automatic seed recovery from a known pad character. It sits between data memory and the DMA/stream fabric and runs at one byte per clock.

## Interface
- `LFSR_W`, default 7: LFSR width; must satisfy 2 ≤ LFSR_W ≤ DATA_W-1.
- `DATA_W`, default 8: stream byte width; MSB carries parity, payload is bits [DATA_W-2:0].
- `PAD_CHAR`, default 8'h20: known plaintext of the first byte, used for seed recovery.

Ports:
- `Clk` in 1: sole clock; all logic samples on the rising edge.
- `Reset` in 1: synchronous, active-low reset.
- `cfg_load` in 1: single-cycle pulse that latches `cfg_taps`, `cfg_seed` and `cfg_mode`, then restarts the engine.
- `cfg_taps` in LFSR_W: feedback tap mask.
- `cfg_seed` in LFSR_W: initial LFSR state; 0 is replaced by 1.
- `cfg_mode` in 2: 0 = encrypt, 1 = decrypt, 2 = decrypt-autoseed, 3 = reserved (treated as 1).
- `in_valid` in 1 / `in_ready` out 1 / `in_data` in DATA_W: input stream.
- `out_valid` out 1 / `out_ready` in 1 / `out_data` out DATA_W: output stream.
- `out_perr` out 1: parity error on the current output byte; qualified by `out_valid`.
- `seed_err` out 1: sticky; autoseed recovered an all-zero seed.
- `seed_out` out LFSR_W: seed in use, either configured or recovered.
- `perr_cnt` out 8: saturating count of parity errors since the last `cfg_load`.

## Operation
- **LFSR step:** `next = {state[LFSR_W-2:0], ^(state & taps)}`. The state advances once per accepted input byte, never otherwise.
- **Keystream mask:** `ks = state`, zero-extended to DATA_W-1 bits.
- **Encrypt:** `p = in_data[DATA_W-2:0] ^ ks`; `out_data = {^p, p}`. Input MSB is ignored. `out_perr` = 0.
- **Decrypt:** `out_data = {1'b0, in_data[DATA_W-2:0] ^ ks}`; `out_perr = in_data[DATA_W-1] ^ (^in_data[DATA_W-2:0])`.
- **Decrypt-autoseed:** the first accepted byte sets `seed = in_data[DATA_W-2:0] ^ PAD_CHAR[LFSR_W-1:0]`. That byte is emitted as PAD_CHAR with the normal parity check applied. The LFSR then loads `next(seed)` and decryption continues normally.
  - If the recovered seed is 0: `seed_err` is set, the byte is emitted as PAD_CHAR, and the FSM stays in SEED for the next byte.
- **FSM states:** UNCFG, SEED, RUN.
  - Reset → UNCFG.
  - `cfg_load` from any state → SEED if mode = 2, else RUN.
  - SEED → RUN on the first accepted byte with a nonzero recovered seed.
  - In UNCFG, `in_ready` = 0.
- **cfg_load mid-stream:** drops any pending output (`out_valid` → 0 next cycle), clears `perr_cnt` and `seed_err`, and reloads state. An input handshake in the same cycle is discarded.

## Timing
- **Reset values:** FSM = UNCFG; all of `out_valid`, `out_data`, `out_perr`, `seed_err`, `seed_out`, `perr_cnt`, taps, state and mode = 0; `in_ready` = 0.
- **Output register:** single stage; latency is 1 cycle from input handshake to `out_valid`.
- **Ready:** `in_ready = (state != UNCFG) && !cfg_load && (!out_valid || out_ready)`. Full throughput of 1 byte/cycle when `out_ready` is held high.
- **Hold rule:** while `out_valid && !out_ready`, `out_data` and `out_perr` hold stable and no input is accepted.
- **perr_cnt:** increments on the output-accept cycle of an errored byte and saturates at 255.
- **Reset mid-stream:** Reset low for one rising edge returns every output to its reset value, including loss of configuration.

## Configuration
- `LFSR_CIPHER_PERR_EN`
  - **Defined:** parity check, `out_perr` and `perr_cnt` behave as specified above.
  - **Undefined:** checker logic is removed, `out_perr` and `perr_cnt` are tied to 0, and decrypt output is unchanged.
  - Encrypt parity generation is present in both cases.

## Test plan
- **Encrypt:** taps 0x7E, seed 0x05, mode 0, inputs 0x20, 0x20 → out 0xA5, 0x2B; states 0x05 then 0x0B.
- **Decrypt:** same config, mode 1, inputs 0xA5, 0x2B → out 0x20, 0x20 with `out_perr` 0. Input 0x25 as the first byte → out 0x20, `out_perr` 1, `perr_cnt` 1 (macro defined) or 0 (undefined).
- **Autoseed:** taps 0x7E, mode 2, `cfg_seed` ignored, inputs 0xA5, 0x2B → `seed_out` 0x05, outputs 0x20, 0x20. First input 0x20 → `seed_err` 1, FSM stays in SEED.
- **Backpressure:** a 64-byte stream with `out_ready` low for 3 cycles mid-stream → `out_data` stable, `in_ready` 0 throughout the stall, no byte lost or duplicated, output matches the reference model.
- **Zero seed and width:** `cfg_seed` 0 → `seed_out` 1. Parameterise LFSR_W = 5, DATA_W = 8, then round-trip 64 random bytes through encrypt then decrypt → plaintext payload bits restored exactly.
- **Reset and reconfigure:** Reset low while `out_valid` is high → all outputs 0 and `in_ready` 0 the next cycle. `cfg_load` mid-stream → pending output dropped and the keystream restarts from the new seed.
